// File: rtl/regfile_sb.sv
// Multi-read-port register file with a write-pending scoreboard for the ID stage.
// Define REGFILE_SB_BYPASS_EN to forward a same-cycle writeback to the read ports.

module regfile_sb_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic [ADDR_W-1:0]             raddr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem_i,
  input  logic [DEPTH-1:0]              busy_i,
  input  logic                          fwd_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          rbusy_o
);
  assign rdata_o = fwd_i ? wdata_i : mem_i[raddr_i];
  assign rbusy_o = fwd_i ? 1'b0    : busy_i[raddr_i];
endmodule

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [NREAD*ADDR_W-1:0]   raddr,
  output logic [NREAD*DATA_W-1:0]   rdata,
  output logic [NREAD-1:0]          rbusy,
  input  logic                      iss_valid,
  input  logic [ADDR_W-1:0]         iss_addr,
  output logic [(1<<ADDR_W)-1:0]    busy_vec,
  output logic [ADDR_W:0]           busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
    $error("regfile_sb: NREAD must be in 1..4");
  end

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [ADDR_W:0]              cnt_q, cnt_d;
  logic                         wr_en, iss_en, cnt_inc, cnt_dec;

  assign wr_en  = we && (waddr != '0);
  assign iss_en = iss_valid && (iss_addr != '0);

  // Clear first, then set: a new producer on the same index supersedes the old one.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[waddr]    = 1'b0;
    if (iss_en) busy_d[iss_addr] = 1'b1;
  end

  // Counter tracks 0->1 and 1->0 transitions only, so it stays equal to the popcount.
  always_comb begin
    cnt_inc = iss_en && !busy_q[iss_addr];
    cnt_dec = wr_en && busy_q[waddr] && !(iss_en && (iss_addr == waddr));
    cnt_d   = cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) mem_q[waddr] <= wdata;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  logic [NREAD-1:0][ADDR_W-1:0] ra;
  logic [NREAD-1:0][DATA_W-1:0] rd;
  logic [NREAD-1:0]             fwd;

  assign ra    = raddr;
  assign rdata = rd;

  for (genvar i = 0; i < NREAD; i++) begin : g_port
`ifdef REGFILE_SB_BYPASS_EN
    assign fwd[i] = wr_en && (ra[i] == waddr);
`else
    assign fwd[i] = 1'b0;
`endif
    regfile_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd (
      .raddr_i (ra[i]),
      .mem_i   (mem_q),
      .busy_i  (busy_q),
      .fwd_i   (fwd[i]),
      .wdata_i (wdata),
      .rdata_o (rd[i]),
      .rbusy_o (rbusy[i])
    );
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read-port register file with an integrated write-pending scoreboard, successor to the fixed 32x32 two-port regfile. It sits in the ID stage of the pipelined CPU.
- Supplies NREAD operands per cycle.
- Tracks which destination registers have an instruction in flight (issue → writeback), so hazard/stall logic can read busy flags directly.
- Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
NREAD, 2, number of independent combinational read ports (1..4)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
we  input  1  writeback enable
waddr  input  ADDR_W  writeback register index
wdata  input  DATA_W  writeback data
raddr  input  NREAD*ADDR_W  packed read indices; port i = bits [i*ADDR_W +: ADDR_W]
rdata  output  NREAD*DATA_W  packed read data, same packing
rbusy  output  NREAD  per-port flag: register read on port i has a pending write
iss_valid  input  1  instruction issued with a destination register
iss_addr  input  ADDR_W  destination index of the issued instruction
busy_vec  output  DEPTH  current scoreboard bits, bit k = register k pending
busy_cnt  output  ADDR_W+1  number of set bits in busy_vec

Behaviour:
- Reset: on posedge clk with rst=1, all registers ← 0, busy_vec ← 0, busy_cnt ← 0. rst overrides we and iss_valid in that cycle. Reset mid-operation discards all pending state. Outputs therefore read 0 / not-busy from the cycle after the reset edge.
- Write: on posedge, if we && waddr != 0, reg[waddr] ← wdata. Writes to index 0 are dropped. reg[0] always reads 0.
- Read: rdata port i is combinational from reg[raddr_i], zero latency, with ports fully independent. Any number of ports may read the same index.
- Scoreboard set: on posedge, if iss_valid && iss_addr != 0, busy[iss_addr] ← 1.
- Scoreboard clear: on posedge, if we && waddr != 0, busy[waddr] ← 0.
- Same-index collision, issue and writeback on the same cycle and index: set wins. The bit stays/becomes 1 because the new producer supersedes the old one.
- Single-outstanding model:
  - Issue to an already-busy register leaves the bit at 1 and busy_cnt unchanged.
  - Writeback to a non-busy register writes data and leaves busy_cnt unchanged.
- busy_cnt is a registered counter, not a popcount. Each cycle it moves by +1 (a 0→1 transition), −1 (a 1→0 transition) or 0, for a net range of −1..+1. It must always equal popcount(busy_vec). Maximum value is DEPTH−1 because reg 0 is never busy, so no overflow.
- rbusy[i] = busy[raddr_i] from current state. It is always 0 for raddr_i = 0. An issue in the current cycle affects rbusy only from the next cycle.
- Invalid NREAD (0 or >4) stops elaboration via a generate-time error.

Optional Feature:
Macro REGFILE_SB_BYPASS_EN.
- Defined: write-through forwarding. If we && waddr != 0 && raddr_i == waddr, then rdata port i = wdata and rbusy[i] = 0 in that same cycle, and a read sees a same-cycle writeback with no stall.
- Undefined: rdata port i returns the pre-write array value and rbusy[i] reflects the pre-clear busy bit. Hazard logic must stall one extra cycle.

Test Plan:
- Reset then read: preload reg 5 = 32'h1234 via we. Assert rst for 1 cycle → after the edge, every rdata port reads 0 for raddr 0..31, busy_vec = 0, busy_cnt = 0.
- Reg 0 protection: we=1, waddr=0, wdata=32'hFFFF_FFFF; then iss_valid=1, iss_addr=0 → rdata for raddr=0 is 0, busy_vec[0]=0, busy_cnt=0.
- Issue/writeback sequence:
  - Issue 3, 7, 3 on consecutive cycles → busy_cnt 1, 2, 2.
  - Writeback 7 with 32'hAA → busy_cnt 1, rbusy=0 on a port reading 7, rdata=32'hAA.
  - Writeback 3 → busy_cnt 0.
- Collision: reg 9 busy; same cycle iss_addr=9 and we with waddr=9, wdata=32'h55 → next cycle busy[9]=1, busy_cnt unchanged, reg 9 = 32'h55.
- Bypass: with NREAD=3 and all ports reading reg 4, which is busy, drive we with waddr=4, wdata=32'hBEEF.
  - With REGFILE_SB_BYPASS_EN: all three ports show 32'hBEEF, rbusy=3'b000 in that cycle.
  - Without it: old value, rbusy=3'b111; next cycle 32'hBEEF, 3'b000.
- Random stress, ADDR_W=3, DATA_W=16: 2000 cycles of random we/iss/raddr against a reference model → rdata, busy_vec and busy_cnt match every cycle, and busy_cnt == popcount(busy_vec) always.
